// File: rtl/ex_issue_ctrl.sv
// EX-stage sequencing: holds the front end during multi-cycle multiplies, marks result-valid
// cycles, raises branch flush strobes and keeps saturating stall/branch counters.
module ex_issue_ctrl #(
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned CNT_W     = 32,
  parameter logic [4:0]  ALU_MUL   = 5'h0a,
  parameter logic [4:0]  ALU_MULHU = 5'h0d
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_valid,
  input  logic [4:0]       id_ex_alu_func,
  input  logic             id_ex_is_branch,
  input  logic             ex_take_branch,
  output logic             ex_fire,
  output logic             ex_stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [3:0]       busy_cnt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [15:0]      taken_branches
);

  typedef enum logic [0:0] {StIdle, StMulWait} state_e;

  localparam bit         MulMulti = (MUL_LAT >= 2);
  // The IDLE cycle is the first of the MUL_LAT cycles, so the wait counter starts at MUL_LAT-2.
  localparam logic [3:0] BusyInit = MulMulti ? 4'(MUL_LAT - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] busy_q, busy_d;
  logic       is_mul;
  logic       flush;

  assign is_mul = id_ex_valid & ((id_ex_alu_func == ALU_MUL) | (id_ex_alu_func == ALU_MULHU));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      busy_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (is_mul && MulMulti) begin
          state_d = StMulWait;
          busy_d  = BusyInit;
        end
      end
      StMulWait: begin
        if (busy_q != 4'd0) busy_d = busy_q - 4'd1;
        else                state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ex_fire  = 1'b0;
    ex_stall = 1'b0;
    if (rst) begin
      unique case (state_q)
        StIdle: begin
          if (id_ex_valid) begin
            if (is_mul && MulMulti) ex_stall = 1'b1;
            else                    ex_fire  = 1'b1;
          end
        end
        StMulWait: begin
          if (busy_q != 4'd0) ex_stall = 1'b1;
          else                ex_fire  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign flush      = ex_fire & id_ex_is_branch & ex_take_branch;
  assign flush_ifid = flush;
  assign flush_idex = flush;
  assign busy_cnt   = busy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles   <= '0;
      taken_branches <= 16'd0;
    end else begin
      if (ex_stall && (stall_cycles != {CNT_W{1'b1}})) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush && (taken_branches != 16'hFFFF)) taken_branches <= taken_branches + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Self-checking bench for ex_issue_ctrl: directed cases plus randomized traffic checked
// against an op-age reference model.
module tb_ex_issue_ctrl;

  localparam int unsigned Lat   = 3;
  localparam logic [4:0]  Mul   = 5'h0a;
  localparam logic [4:0]  Mulhu = 5'h0d;
  localparam logic [4:0]  Add   = 5'h00;

  logic        clk = 1'b0;
  logic        rst, valid, is_branch, take_branch;
  logic [4:0]  alu_func;
  logic        ex_fire, ex_stall, flush_ifid, flush_idex;
  logic [3:0]  busy_cnt;
  logic [31:0] stall_cycles;
  logic [15:0] taken_branches;

  // Narrow-counter instance for saturation, MUL_LAT=2.
  logic        s_rst;
  logic        s_fire, s_stall, s_fl_ifid, s_fl_idex;
  logic [3:0]  s_busy;
  logic [1:0]  s_stall_cycles;
  logic [15:0] s_taken;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: age = cycles the current multiply has already spent in EX.
  int     age = 0;
  longint m_stall = 0;
  int     m_taken = 0;

  always #5 clk = ~clk;

  ex_issue_ctrl #(.MUL_LAT(Lat), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_ex_valid(valid), .id_ex_alu_func(alu_func),
    .id_ex_is_branch(is_branch), .ex_take_branch(take_branch),
    .ex_fire(ex_fire), .ex_stall(ex_stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .busy_cnt(busy_cnt), .stall_cycles(stall_cycles), .taken_branches(taken_branches)
  );

  ex_issue_ctrl #(.MUL_LAT(2), .CNT_W(2)) s_dut (
    .clk(clk), .rst(s_rst), .id_ex_valid(1'b1), .id_ex_alu_func(Mul),
    .id_ex_is_branch(1'b0), .ex_take_branch(1'b0),
    .ex_fire(s_fire), .ex_stall(s_stall), .flush_ifid(s_fl_ifid), .flush_idex(s_fl_idex),
    .busy_cnt(s_busy), .stall_cycles(s_stall_cycles), .taken_branches(s_taken)
  );

  always @(negedge clk) assert (!(flush_ifid && ex_stall));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, compare all outputs with the model, then advance one edge.
  task automatic step(input logic r, input logic v, input logic [4:0] f,
                      input logic b, input logic t);
    logic mul, e_stall, e_fire, e_flush;
    int   e_busy;
    rst = r; valid = v; alu_func = f; is_branch = b; take_branch = t;
    #1;
    mul     = v && (f == Mul || f == Mulhu);
    e_stall = r && mul && (Lat >= 2) && (age < int'(Lat) - 1);
    e_fire  = r && v && !e_stall;
    e_flush = e_fire && b && t;
    e_busy  = (age == 0) ? 0 : int'(Lat) - 1 - age;
    check("ex_fire", {31'd0, ex_fire}, {31'd0, e_fire});
    check("ex_stall", {31'd0, ex_stall}, {31'd0, e_stall});
    check("flush_ifid", {31'd0, flush_ifid}, {31'd0, e_flush});
    check("flush_idex", {31'd0, flush_idex}, {31'd0, e_flush});
    check("busy_cnt", {28'd0, busy_cnt}, e_busy);
    check("stall_cycles", stall_cycles, m_stall[31:0]);
    check("taken_branches", {16'd0, taken_branches}, m_taken);
    @(posedge clk);
    if (!r) begin
      age = 0; m_stall = 0; m_taken = 0;
    end else begin
      age = e_stall ? age + 1 : 0;
      if (e_stall && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (e_flush && m_taken < 65535) m_taken++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic       r, v, b, t, mul;
    logic [4:0] f;
    int         s_exp;
    rst = 1'b0; s_rst = 1'b0; valid = 1'b0; alu_func = Add; is_branch = 1'b0;
    take_branch = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset then idle.
    step(0, 0, Add, 0, 0);
    step(1, 0, Add, 0, 0);
    check("idle_busy", {28'd0, busy_cnt}, 32'd0);

    // Single ADD.
    step(1, 1, Add, 0, 0);
    check("add_no_stall_count", stall_cycles, 32'd0);

    // Single MUL.
    step(0, 0, Add, 0, 0);
    repeat (3) step(1, 1, Mul, 0, 0);
    check("mul_stall_total", stall_cycles, 32'd2);

    // MUL then MULHU back-to-back.
    step(0, 0, Add, 0, 0);
    repeat (3) step(1, 1, Mul, 0, 0);
    repeat (3) step(1, 1, Mulhu, 0, 0);
    check("b2b_stall_total", stall_cycles, 32'd4);

    // Taken and not-taken branch.
    step(0, 0, Add, 0, 0);
    step(1, 1, Add, 1, 1);
    check("taken_once", {16'd0, taken_branches}, 32'd1);
    step(1, 1, Add, 1, 0);
    check("not_taken_hold", {16'd0, taken_branches}, 32'd1);

    // Reset in the middle of a multiply: no fire afterwards.
    step(0, 0, Add, 0, 0);
    step(1, 1, Mul, 0, 0);
    step(0, 1, Mul, 0, 0);
    check("midreset_busy", {28'd0, busy_cnt}, 32'd0);
    repeat (4) step(1, 0, Add, 0, 0);

    // Randomized traffic; inputs are held while the model says EX is occupied.
    v = 1'b0; f = Add; b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 39) != 0);
      if (age == 0) begin
        v = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: f = Mul;
          1: f = Mulhu;
          2: f = Add;
          default: f = 5'($urandom_range(0, 31));
        endcase
        mul = (f == Mul || f == Mulhu);
        b = v && !mul && ($urandom_range(0, 2) == 0);
        t = b && ($urandom_range(0, 1) == 1);
      end else begin
        t = 1'b0;
      end
      step(r, v, f, b, t);
    end

    // Saturation on a 2-bit stall counter with MUL_LAT=2.
    s_exp = 0;
    for (int i = 0; i < 10; i++) begin
      s_rst = 1'b1;
      #1;
      check("sat_stall", {31'd0, s_stall}, {31'd0, (i % 2) == 0});
      check("sat_fire", {31'd0, s_fire}, {31'd0, (i % 2) == 1});
      @(posedge clk);
      if ((i % 2) == 0 && s_exp < 3) s_exp++;
      @(negedge clk);
      check("sat_count", {30'd0, s_stall_cycles}, s_exp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
